// File: rtl/uart_param_pkg.sv
// conf_t: shared UART configuration types, FSM states and baud divider helpers.
// UART_PARAM_PARITY_EN compiles in parity generation and checking.
package conf_t;
    typedef enum logic [2:0] {
        br_9600, br_19200, br_38400, br_57600, br_115200, br_230400, br_460800, br_921600
    } br;
    typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} par_t;
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;
`ifdef UART_PARAM_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam br BR_SLOWEST = br_9600;
    function automatic int baud_hz(br b);
        case (b)
            br_9600:   return 9600;
            br_19200:  return 19200;
            br_38400:  return 38400;
            br_57600:  return 57600;
            br_115200: return 115200;
            br_230400: return 230400;
            br_460800: return 460800;
            br_921600: return 921600;
            default:   return 115200;
        endcase
    endfunction
    function automatic int div_of(int clk_hz, int ovs, br b);
        int d;
        d = clk_hz / (baud_hz(b) * ovs);
        return d < 1 ? 1 : d;
    endfunction
endpackage

// File: rtl/uart_param_baud_tick.sv
// uart_baud_tick: one-cycle oversampling tick every CLK_HZ/(baud*OVS) cycles.
module uart_baud_tick import conf_t::*; #(
    parameter int CLK_HZ = 50_000_000,
    parameter int OVS    = 16
) (
    input  logic osc,
    input  logic rst,
    input  br    baud,
    output logic tick
);
    localparam int DW = $clog2(div_of(CLK_HZ, OVS, BR_SLOWEST) + 1);
    logic [DW-1:0] div_tbl [8];
    logic [DW-1:0] cnt;
    logic [DW-1:0] lim;
    // Divider limits are elaboration-time constants, so baud only drives a mux.
    for (genvar i = 0; i < 8; i++) begin : g_div
        assign div_tbl[i] = DW'(div_of(CLK_HZ, OVS, br'(i)) - 1);
    end
    assign lim = div_tbl[baud];
    always_ff @(posedge osc) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= cnt >= lim;
            cnt  <= cnt >= lim ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/uart_param.sv
// uart_param: parameterised UART, TX and RX running concurrently off one shared tick.
// Parity support is compiled in with UART_PARAM_PARITY_EN; otherwise rx_par_err stays 0.
module uart_param import conf_t::*; #(
    parameter int CLK_HZ = 50_000_000,
    parameter int DATA_W = 8,
    parameter int OVS    = 16
) (
    input  logic              osc,
    input  logic              rst,
    input  br                 baud,
    input  par_t              parity,
    input  logic              stop2,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    input  logic              rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_frame_err,
    output logic              rx_par_err
);
    localparam int OW = $clog2(OVS);
    localparam int BW = $clog2(DATA_W);
    br           baud_q;
    par_t        par_q;
    logic        tick;
    logic        par_on;
    logic        par_odd;
    state_t      tx_st;
    logic [OW-1:0] tx_os;
    logic [BW-1:0] tx_n;
    logic [DATA_W-1:0] tx_sh;
    logic        tx_s2;
    logic        tx_p;
    logic        tx_bnd;
    state_t      rx_st;
    logic [OW-1:0] rx_os;
    logic [BW-1:0] rx_n;
    logic [DATA_W-1:0] rx_sh;
    logic        rx_p;
    logic        rx_s1;
    logic        rx_s2;
    logic        rx_d;
    logic        rx_smp;

    uart_baud_tick #(.CLK_HZ(CLK_HZ), .OVS(OVS)) u_tick (
        .osc  (osc),
        .rst  (rst),
        .baud (baud_q),
        .tick (tick)
    );

    assign par_on  = PAR_EN && par_q != PAR_NONE;
    assign par_odd = par_q == PAR_ODD;
    assign tx_bnd  = tick && tx_os == OW'(OVS - 1);
    assign rx_smp  = tick && rx_os == OW'(OVS - 1);

    // Configuration only follows the inputs while neither direction is mid-frame.
    always_ff @(posedge osc) begin
        if (rst || (tx_st == IDLE && rx_st == IDLE)) begin
            baud_q <= baud;
            par_q  <= parity;
        end
    end

    always_ff @(posedge osc) begin
        if (rst) begin
            tx_st    <= IDLE;
            tx_os    <= '0;
            tx_n     <= '0;
            tx_sh    <= '0;
            tx_s2    <= 1'b0;
            tx_p     <= 1'b0;
            tx       <= 1'b1;
            tx_ready <= 1'b1;
        end else begin
            if (tick)
                tx_os <= tx_os + 1'b1;
            case (tx_st)
                IDLE: if (tx_valid) begin
                    tx_sh    <= tx_data;
                    tx_p     <= ^tx_data;
                    tx_s2    <= stop2;
                    tx_ready <= 1'b0;
                    tx_st    <= START;
                end
                START: if (tx_bnd) begin
                    tx    <= 1'b0;
                    tx_n  <= '0;
                    tx_st <= DATA;
                end
                DATA: if (tx_bnd) begin
                    tx    <= tx_sh[0];
                    tx_sh <= tx_sh >> 1;
                    tx_n  <= tx_n == BW'(DATA_W - 1) ? '0 : tx_n + 1'b1;
                    if (tx_n == BW'(DATA_W - 1))
                        tx_st <= par_on ? PAR : STOP;
                end
                PAR: if (tx_bnd) begin
                    tx    <= tx_p ^ par_odd;
                    tx_st <= STOP;
                end
                STOP: if (tx_bnd) begin
                    // tx_n counts stop bits already on the line; leave once all have elapsed.
                    if (tx_n == (tx_s2 ? BW'(2) : BW'(1))) begin
                        tx_st    <= IDLE;
                        tx_ready <= 1'b1;
                    end else begin
                        tx   <= 1'b1;
                        tx_n <= tx_n + 1'b1;
                    end
                end
                default: tx_st <= IDLE;
            endcase
        end
    end

    always_ff @(posedge osc) begin
        if (rst) begin
            rx_s1        <= 1'b1;
            rx_s2        <= 1'b1;
            rx_d         <= 1'b1;
            rx_st        <= IDLE;
            rx_os        <= '0;
            rx_n         <= '0;
            rx_sh        <= '0;
            rx_p         <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_par_err   <= 1'b0;
        end else begin
            rx_s1    <= rx;
            rx_s2    <= rx_s1;
            rx_d     <= rx_s2;
            rx_valid <= 1'b0;
            if (tick)
                rx_os <= rx_os + 1'b1;
            case (rx_st)
                IDLE: if (rx_d && !rx_s2) begin
                    rx_os <= '0;
                    rx_st <= START;
                end
                START: if (tick && rx_os == OW'(OVS / 2 - 1)) begin
                    rx_os <= '0;
                    rx_n  <= '0;
                    rx_p  <= 1'b0;
                    rx_st <= rx_s2 ? IDLE : DATA;
                end
                DATA: if (rx_smp) begin
                    rx_sh <= {rx_s2, rx_sh[DATA_W-1:1]};
                    rx_p  <= rx_p ^ rx_s2;
                    rx_n  <= rx_n + 1'b1;
                    if (rx_n == BW'(DATA_W - 1))
                        rx_st <= par_on ? PAR : STOP;
                end
                PAR: if (rx_smp) begin
                    rx_p  <= rx_p ^ rx_s2;
                    rx_st <= STOP;
                end
                STOP: if (rx_smp) begin
                    rx_valid     <= 1'b1;
                    rx_data      <= rx_sh;
                    rx_frame_err <= !rx_s2;
                    rx_par_err   <= par_on && (rx_p ^ par_odd);
                    rx_st        <= rx_s2 ? IDLE : BRK;
                end
                BRK: if (rx_s2)
                    rx_st <= IDLE;
                default: rx_st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_param.sv
// tb_uart_param: table-driven and randomized checks of uart_param against a frame-level model.
module tb_uart_param;
    import conf_t::*;
    localparam int CLK_HZ = 50_000_000;
    localparam int OVS    = 16;
`ifdef UART_PARAM_PARITY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic       osc = 1'b0;
    logic       rst = 1'b1;
    br          baud = br_115200;
    par_t       parity = PAR_NONE;
    logic       stop2 = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx, rx;
    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err, rx_par_err;
    logic       loop = 1'b1;
    logic       rx_drv = 1'b1;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         ev_count = 0;
    logic [7:0] ev_data = 8'h00;
    logic       ev_ferr = 1'b0;
    logic       ev_perr = 1'b0;

    typedef struct {
        logic [7:0]  d;
        par_t        p;
        logic        s2;
        br           b;
        logic [15:0] exp_bits;
        int          exp_n;
    } vec_t;
    vec_t tbl [4];

    assign rx = loop ? tx : rx_drv;

    uart_param #(.CLK_HZ(CLK_HZ), .DATA_W(8), .OVS(OVS)) dut (
        .osc          (osc),
        .rst          (rst),
        .baud         (baud),
        .parity       (parity),
        .stop2        (stop2),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx           (tx),
        .rx           (rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_par_err   (rx_par_err)
    );

    always #5 osc = ~osc;
    always @(posedge osc) cyc <= cyc + 1;
    always @(negedge osc) begin
        if (rx_valid) begin
            ev_count = ev_count + 1;
            ev_data  = rx_data;
            ev_ferr  = rx_frame_err;
            ev_perr  = rx_par_err;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic int bit_cycles(br b);
        int hz;
        hz = (b == br_921600) ? 921600 : 115200;
        return (CLK_HZ / (hz * OVS)) * OVS;
    endfunction

    // Line sequence in transmission order: bit i of 'bits' is the i-th bit on the wire.
    function automatic void model_bits(input logic [7:0] d, input par_t p, input logic s2,
                                       output logic [15:0] bits, output int n);
        bits = '0;
        n = 1;
        for (int i = 0; i < 8; i++) begin
            bits[n] = d[i];
            n++;
        end
        if (PEN && p != PAR_NONE) begin
            bits[n] = (^d) ^ (p == PAR_ODD);
            n++;
        end
        bits[n] = 1'b1;
        n++;
        if (s2) begin
            bits[n] = 1'b1;
            n++;
        end
    endfunction

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge osc);
    endtask

    task automatic set_cfg(input br b, input par_t p, input logic s2);
        baud = b;
        parity = p;
        stop2 = s2;
        repeat (3) @(negedge osc);
    endtask

    task automatic drive_bits(input logic [15:0] bits, input int n, input int p_cyc);
        for (int i = 0; i < n; i++) begin
            rx_drv = bits[i];
            repeat (p_cyc) @(negedge osc);
        end
    endtask

    task automatic do_tx_frame(input string tag, input logic [7:0] d, input par_t p, input logic s2,
                               input br b, input logic [15:0] exp_bits, input int exp_n);
        int p_cyc, t0, k, ev0;
        logic [15:0] cap;
        p_cyc = bit_cycles(b);
        cap = '0;
        set_cfg(b, p, s2);
        ev0 = ev_count;
        tx_data = d;
        tx_valid = 1'b1;
        k = 0;
        while (!tx_ready && k < 10) begin
            @(negedge osc);
            k++;
        end
        @(negedge osc);
        tx_valid = 1'b0;
        k = 0;
        while (tx !== 1'b0 && k < 2 * p_cyc + 8) begin
            @(negedge osc);
            k++;
        end
        chk({tag, "_start"}, tx, 0);
        if (tx !== 1'b0) return;
        t0 = cyc;
        for (int i = 0; i < exp_n; i++) begin
            wait_until(t0 + i * p_cyc + p_cyc / 2);
            cap[i] = tx;
        end
        chk({tag, "_bits"}, cap, exp_bits);
        k = 0;
        while (!tx_ready && k < 4 * p_cyc) begin
            @(negedge osc);
            k++;
        end
        chk({tag, "_busy_cycles"}, cyc - t0, exp_n * p_cyc);
        repeat (4) @(negedge osc);
        chk({tag, "_rx_count"}, ev_count - ev0, 1);
        chk({tag, "_rx_data"}, ev_data, d);
        chk({tag, "_rx_errs"}, {ev_ferr, ev_perr}, 2'b00);
    endtask

    initial begin
        int          p_cyc, ev0, t0, k, n;
        logic [15:0] bits;
        logic [7:0]  d;
        par_t        p;
        logic        s2;

        tbl[0] = '{8'hA5, PAR_NONE, 1'b0, br_115200, 16'h034A, 10};
        tbl[1] = '{8'h3C, PAR_EVEN, 1'b0, br_115200, 16'h0000, 0};
        tbl[2] = '{8'h81, PAR_ODD,  1'b1, br_115200, 16'h0000, 0};
        tbl[3] = '{8'h5A, PAR_NONE, 1'b1, br_921600, 16'h0000, 0};
        for (int i = 1; i < 4; i++) begin
            model_bits(tbl[i].d, tbl[i].p, tbl[i].s2, bits, n);
            tbl[i].exp_bits = bits;
            tbl[i].exp_n = n;
        end

        repeat (4) @(negedge osc);
        chk("reset_tx", tx, 1);
        chk("reset_tx_ready", tx_ready, 1);
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_rx_data", rx_data, 0);
        chk("reset_frame_err", rx_frame_err, 0);
        chk("reset_par_err", rx_par_err, 0);
        rst = 1'b0;
        repeat (3) @(negedge osc);

        for (int i = 0; i < 4; i++)
            do_tx_frame($sformatf("vec%0d", i), tbl[i].d, tbl[i].p, tbl[i].s2, tbl[i].b,
                        tbl[i].exp_bits, tbl[i].exp_n);

        // Odd parity configured but an even parity bit injected on the line.
        loop = 1'b0;
        rx_drv = 1'b1;
        set_cfg(br_115200, PAR_ODD, 1'b0);
        p_cyc = bit_cycles(br_115200);
        ev0 = ev_count;
        drive_bits(16'h0602, 11, p_cyc);
        rx_drv = 1'b1;
        repeat (p_cyc) @(negedge osc);
        chk("bad_par_count", ev_count - ev0, 1);
        chk("bad_par_data", ev_data, 8'h01);
        chk("bad_par_flag", ev_perr, PEN);
        chk("bad_par_ferr", ev_ferr, 0);

        // Stop bit 0 followed by a long break: a single frame error only.
        set_cfg(br_115200, PAR_NONE, 1'b0);
        ev0 = ev_count;
        drive_bits(16'h00AA, 10, p_cyc);
        rx_drv = 1'b0;
        repeat (30 * p_cyc) @(negedge osc);
        chk("break_count", ev_count - ev0, 1);
        chk("break_ferr", ev_ferr, 1);
        chk("break_data", ev_data, 8'h55);
        rx_drv = 1'b1;
        repeat (2 * p_cyc) @(negedge osc);
        ev0 = ev_count;
        model_bits(8'hA3, PAR_NONE, 1'b0, bits, n);
        drive_bits(bits, n, p_cyc);
        repeat (p_cyc) @(negedge osc);
        chk("after_break_count", ev_count - ev0, 1);
        chk("after_break_data", ev_data, 8'hA3);
        chk("after_break_ferr", ev_ferr, 0);

        // 100-cycle glitch is a false start; a frame at cycle 300 must be received intact.
        ev0 = ev_count;
        t0 = cyc;
        rx_drv = 1'b0;
        repeat (100) @(negedge osc);
        rx_drv = 1'b1;
        wait_until(t0 + 300);
        chk("glitch_no_valid", ev_count - ev0, 0);
        model_bits(8'h6E, PAR_NONE, 1'b0, bits, n);
        drive_bits(bits, n, p_cyc);
        repeat (p_cyc) @(negedge osc);
        chk("post_glitch_count", ev_count - ev0, 1);
        chk("post_glitch_data", ev_data, 8'h6E);
        chk("post_glitch_ferr", ev_ferr, 0);

        // Reset during data bit 3 of a looped-back transmission.
        loop = 1'b1;
        set_cfg(br_921600, PAR_NONE, 1'b0);
        p_cyc = bit_cycles(br_921600);
        tx_data = 8'hF0;
        tx_valid = 1'b1;
        @(negedge osc);
        tx_valid = 1'b0;
        k = 0;
        while (tx !== 1'b0 && k < 2 * p_cyc + 8) begin
            @(negedge osc);
            k++;
        end
        t0 = cyc;
        wait_until(t0 + 4 * p_cyc + p_cyc / 2);
        chk("rst_pre_bit3", tx, 0);
        ev0 = ev_count;
        rst = 1'b1;
        @(negedge osc);
        chk("rst_tx_high", tx, 1);
        chk("rst_tx_ready", tx_ready, 1);
        rst = 1'b0;
        repeat (12 * p_cyc) @(negedge osc);
        chk("rst_no_valid", ev_count - ev0, 0);
        model_bits(8'h55, PAR_NONE, 1'b0, bits, n);
        do_tx_frame("post_rst", 8'h55, PAR_NONE, 1'b0, br_921600, bits, n);

        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom_range(0, 255));
            p = par_t'($urandom_range(0, 2));
            s2 = 1'($urandom_range(0, 1));
            model_bits(d, p, s2, bits, n);
            do_tx_frame($sformatf("rand%0d", i), d, p, s2, br_921600, bits, n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_param.md
UART_PARAM -- requirements
Module: uart_param

Interface
REQ-001 Parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter DATA_W, default 8, data bits per frame; legal range 5..9.
REQ-003 Parameter OVS, default 16, RX oversampling factor; power of two, range 8..16.
REQ-004 Port osc  in  1  system clock; all logic is on posedge osc.
REQ-005 Port rst  in  1  reset, synchronous, active-high.
REQ-006 Port baud  in  conf_t::br  baud-rate select; sampled only while TX and RX are both idle.
REQ-007 Port parity  in  conf_t::par_t  parity mode: PAR_NONE, PAR_EVEN or PAR_ODD.
REQ-008 Port stop2  in  1  1 = two stop bits on TX; RX checks the first stop bit only.
REQ-009 Port tx_data  in  DATA_W  byte to send, LSB first.
REQ-010 Port tx_valid / tx_ready  in / out  1  TX handshake.
REQ-011 Port tx  out  1  serial output; idles high.
REQ-012 Port rx  in  1  asynchronous serial input.
REQ-013 Port rx_data  out  DATA_W  last received word.
REQ-014 Port rx_valid  out  1  one-cycle strobe per received frame.
REQ-015 Port rx_frame_err / rx_par_err  out  1  error flags; valid with rx_valid.

Function
REQ-016 Tick divider: DIV = CLK_HZ/(baud*OVS), integer-truncated; tick pulses for 1 osc cycle every DIV cycles. TX bit period = OVS ticks.
REQ-017 TX FSM states: IDLE, START, DATA, PAR, STOP. tx_ready = 1 only in IDLE.
REQ-018 TX transfer occurs when tx_valid && tx_ready; tx_data is latched and START is entered. tx falls at the next bit-period boundary.
REQ-019 TX bit sequence: start 0, then DATA_W bits LSB first, then parity if enabled, then 1 or 2 stop bits of 1. Return to IDLE after the last stop bit.
REQ-020 Parity bit = XOR of data bits for EVEN, inverted for ODD.
REQ-021 RX passes through a 2-flop synchroniser before any use.
REQ-022 RX FSM states: IDLE, START, DATA, PAR, STOP.
REQ-023 RX falling edge in IDLE moves to START. At OVS/2 ticks, rx low continues the frame; rx high (false start) returns to IDLE with no strobe.
REQ-024 RX samples each following bit every OVS ticks, at bit centre.
REQ-025 At the stop sample, RX updates rx_data and the error flags and pulses rx_valid for exactly 1 cycle.
REQ-026 rx_frame_err = stop sample was 0. rx_par_err = parity mismatch; always 0 when parity is PAR_NONE.
REQ-027 After a frame error, RX waits for rx high before re-arming IDLE; it does not report a break as repeated frames.
REQ-028 TX and RX run fully concurrently and independently.
REQ-029 Changes to baud or parity mid-frame are ignored until both FSMs are idle.

Reset
REQ-030 rst sets tx = 1, tx_ready = 1, rx_valid = 0, both error flags = 0, rx_data = 0, both FSMs to IDLE and the divider to 0.
REQ-031 rst asserted mid-frame aborts the frame; tx is high on the cycle after rst and no rx_valid is issued.

Configuration
REQ-032 Macro UART_PARAM_PARITY_EN: when defined, parity generation and checking operate per REQ-019/020/026.
REQ-033 Without UART_PARAM_PARITY_EN, the parity port is ignored, no PAR state is synthesised and rx_par_err is tied to 0.

Structure
REQ-034 Package conf_t holds br (existing) and the new par_t enum, plus localparam helpers for DIV computation.
REQ-035 Sub-module uart_baud_tick generates the OVS tick; it is shared by TX and RX.

Verification
REQ-036 Setup for REQ-037..040: CLK_HZ = 50 MHz, br_115200, OVS = 16, so DIV = 27. Send tx_data = 8'hA5, PAR_NONE, stop2 = 0: tx shows 0,1,0,1,0,0,1,0,1,1 at 432-cycle bit spacing; tx_ready is low for 10 bit periods.
REQ-037 Loop tx to rx and send 8'h3C with PAR_EVEN: rx_valid pulses once, rx_data = 8'h3C, both error flags = 0.
REQ-038 Drive 8'h01 with PAR_ODD but inject an even parity bit: rx_par_err = 1, rx_data = 8'h01.
REQ-039 Drive a frame whose stop bit is 0, then hold rx low for 3 frame times: exactly one rx_valid with rx_frame_err = 1, and none during the low period.
REQ-040 Drive a 100-cycle low glitch on rx: no rx_valid is issued, and RX is back in IDLE before cycle 300.
REQ-041 Assert rst during the 4th data bit of TX: tx = 1 next cycle, tx_ready = 1, and a new 8'h55 transmits correctly.
